// File: rtl/sub16bit_serial.sv
// sub16bit_serial: multi-cycle Y = A - B - Bin, one SLICE-bit slice per clock.
// Borrow ripples through a flop between slices; results hold until the next op.
module sub16bit_serial #(
  parameter int W     = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Y,
  output logic         Bout,
  output logic         OV,
  output logic         Z
);

  localparam int N  = W / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  work_q;
  logic [W-1:0]  work_d;
  logic [CW-1:0] cnt_q;
  logic          borrow_q;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  y_q;
  logic          bout_q;
  logic          ov_q;
  logic          z_q;

  logic [IW-1:0]    base;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] d_sl;
  logic [SLICE:0]   brw_ext;
  logic             b_sl_out;

  // One slice of the ripple: extra top bit of the difference is the borrow.
  always_comb begin
    base       = IW'(cnt_q) * IW'(SLICE);
    a_sl       = a_q[base +: SLICE];
    b_sl       = b_q[base +: SLICE];
    brw_ext    = '0;
    brw_ext[0] = borrow_q;
    {b_sl_out, d_sl} = {1'b0, a_sl} - {1'b0, b_sl} - brw_ext;
    work_d     = work_q;
    work_d[base +: SLICE] = d_sl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_q      <= '0;
      bout_q   <= 1'b0;
      ov_q     <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
            work_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          work_q   <= work_d;
          borrow_q <= b_sl_out;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          y_q     <= work_q;
          bout_q  <= borrow_q;
          ov_q    <= (a_q[W-1] ^ b_q[W-1])
                   & (work_q[W-1] ^ a_q[W-1]);
          z_q     <= ~|work_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;
  assign Bout = bout_q;
  assign OV   = ov_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_sub16bit_serial.sv
// tb_sub16bit_serial: directed + random checks of sub16bit_serial.
// Expected results are queued at issue and popped on each done pulse.
module tb_sub16bit_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Bin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] Y;
  logic        Bout;
  logic        OV;
  logic        Z;

  sub16bit_serial #(
    .W(16),
    .SLICE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(A),
    .B(B),
    .Bin(Bin),
    .busy(busy),
    .done(done),
    .Y(Y),
    .Bout(Bout),
    .OV(OV),
    .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] y;
    logic        bout;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t  q[$];
  int    tests = 0;
  int    fails = 0;
  int    dones = 0;
  int    cyc = 0;
  logic  prev_rst = 1'b0;
  logic [31:0] last = '0;
  exp_t  e;

  function automatic exp_t model(logic [15:0] a, logic [15:0] b,
                                 logic bin);
    exp_t        r;
    logic [16:0] t;
    t      = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    r.y    = t[15:0];
    r.bout = t[16];
    r.ov   = (a[15] != b[15]) && (r.y[15] != a[15]);
    r.z    = (r.y == 16'd0);
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard and hold-stability monitor.
  always @(posedge clk) begin
    #1;
    if (done) begin
      dones++;
      check("queue_nonempty", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("result", {13'd0, Y, Bout, OV, Z},
              {13'd0, e.y, e.bout, e.ov, e.z});
      end
    end else if (rst_n && prev_rst) begin
      check("hold", {13'd0, Y, Bout, OV, Z}, last);
    end
    last     = {13'd0, Y, Bout, OV, Z};
    prev_rst = rst_n;
  end

  task automatic go(input logic [15:0] a, input logic [15:0] b,
                    input logic bin, output int c0);
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    Bin   = bin;
    q.push_back(model(a, b, bin));
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    Bin   = 1'($urandom);
  endtask

  task automatic wait_done(output int c);
    logic got;
    got = 1'b0;
    c   = cyc;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        c   = cyc;
        break;
      end
      check("busy_run", busy, 1);
    end
    check("done_timeout", got, 1);
  endtask

  task automatic run_chk(input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] ey,
                         input logic eb, input logic eo,
                         input logic ez);
    int c0;
    int c1;
    go(a, b, bin, c0);
    check("busy_e0", busy, 1);
    wait_done(c1);
    check("latency", c1 - c0, 5);
    check("busy_at_done", busy, 0);
    check("y", Y, ey);
    check("flags", {Bout, OV, Z}, {eb, eo, ez});
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
  endtask

  initial begin
    int c0;
    int c1;
    int c2;
    int c3;
    int d0;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y", Y, 0);
    check("rst_flags", {Bout, OV, Z}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_chk(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    run_chk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_chk(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_chk(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_chk(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_chk(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

    // Abort an operation mid-RUN with everything non-zero.
    go(16'hAAAA, 16'h1111, 1'b0, c0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_y", Y, 0);
    check("midrst_flags", {Bout, OV, Z}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("postrst_y", Y, 0);
    check("postrst_busy", busy, 0);
    run_chk(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);

    // start during busy is ignored.
    d0 = dones;
    go(16'h4000, 16'h0001, 1'b1, c0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    A     = 16'hFFFF;
    B     = 16'h0000;
    Bin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c1);
    check("ign_y", Y, 16'h3FFE);
    repeat (10) @(posedge clk);
    #1;
    check("ign_one_done", dones - d0, 1);

    // start held high re-issues every N+2 cycles.
    d0 = dones;
    @(negedge clk);
    start = 1'b1;
    A     = 16'h0F0F;
    B     = 16'hF0F0;
    Bin   = 1'b1;
    repeat (3) q.push_back(model(16'h0F0F, 16'hF0F0, 1'b1));
    wait_done(c1);
    check("held_y", Y, 16'h1E1E);
    check("held_flags", {Bout, OV, Z}, 3'b100);
    wait_done(c2);
    check("held_gap1", c2 - c1, 6);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c3);
    check("held_gap2", c3 - c2, 6);
    repeat (10) @(posedge clk);
    #1;
    check("held_three", dones - d0, 3);

    for (int i = 0; i < 10000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      go(ra, rb, rbin, c0);
      wait_done(c1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
